// File: rtl/id_ex_alu_issue_pkg.sv
// Shared constants for the ID->EX ALU issue stage: ALU opcodes, MIPS op/funct codes,
// operand-select codes and the decoder output record.
package id_ex_alu_issue_pkg;

    localparam int ALU_OP_LENGTH = 4;
    localparam int WORD_WIDTH    = 32;

    localparam logic [ALU_OP_LENGTH-1:0] ALU_ADD      = 4'd0;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_SUB      = 4'd1;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_AND      = 4'd2;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OR       = 4'd3;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_XOR      = 4'd4;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_NOR      = 4'd5;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_SLT      = 4'd6;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_SLTU     = 4'd7;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_LS_LEFT  = 4'd8;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_LS_RIGHT = 4'd9;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_AS_RIGHT = 4'd10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        SRC_REG   = 2'd0,
        SRC_SHAMT = 2'd1,
        SRC_IMM   = 2'd2,
        SRC_C16   = 2'd3
    } src_sel_e;

    typedef enum logic {
        EXT_SIGN = 1'b0,
        EXT_ZERO = 1'b1
    } ext_e;

    typedef struct packed {
        logic [ALU_OP_LENGTH-1:0] alu_op;
        src_sel_e                 src_a;
        src_sel_e                 src_b;
        ext_e                     ext;
        logic                     dest_rd;
        logic                     reg_write;
        logic                     mem_write;
        logic                     mem_to_reg;
        logic                     illegal;
    } dec_t;

endpackage

// File: rtl/id_ex_alu_issue_decode.sv
// Purely combinational op/funct decoder: ALU opcode, operand selects, immediate
// extension type and control bits for the ID->EX issue register.
module alu_issue_decode
    import id_ex_alu_issue_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o.alu_op     = ALU_ADD;
        dec_o.src_a      = SRC_REG;
        dec_o.src_b      = SRC_REG;
        dec_o.ext        = EXT_SIGN;
        dec_o.dest_rd    = 1'b0;
        dec_o.reg_write  = 1'b0;
        dec_o.mem_write  = 1'b0;
        dec_o.mem_to_reg = 1'b0;
        dec_o.illegal    = 1'b0;

        if (op_i == OP_RTYPE) begin
            dec_o.dest_rd   = 1'b1;
            dec_o.reg_write = 1'b1;
            case (funct_i)
                FUNCT_ADD, FUNCT_ADDU: dec_o.alu_op = ALU_ADD;
                FUNCT_SUB, FUNCT_SUBU: dec_o.alu_op = ALU_SUB;
                FUNCT_AND:  dec_o.alu_op = ALU_AND;
                FUNCT_OR:   dec_o.alu_op = ALU_OR;
                FUNCT_XOR:  dec_o.alu_op = ALU_XOR;
                FUNCT_NOR:  dec_o.alu_op = ALU_NOR;
                FUNCT_SLT:  dec_o.alu_op = ALU_SLT;
                FUNCT_SLTU: dec_o.alu_op = ALU_SLTU;
                // Constant shifts carry the amount in SrcA; the value stays in SrcB.
                FUNCT_SLL: begin
                    dec_o.alu_op = ALU_LS_LEFT;
                    dec_o.src_a  = SRC_SHAMT;
                end
                FUNCT_SRL: begin
                    dec_o.alu_op = ALU_LS_RIGHT;
                    dec_o.src_a  = SRC_SHAMT;
                end
                FUNCT_SRA: begin
                    dec_o.alu_op = ALU_AS_RIGHT;
                    dec_o.src_a  = SRC_SHAMT;
                end
                FUNCT_SLLV: dec_o.alu_op = ALU_LS_LEFT;
                FUNCT_SRLV: dec_o.alu_op = ALU_LS_RIGHT;
                FUNCT_SRAV: dec_o.alu_op = ALU_AS_RIGHT;
                default: begin
                    dec_o.illegal   = 1'b1;
                    dec_o.reg_write = 1'b0;
                end
            endcase
        end else begin
            dec_o.src_b     = SRC_IMM;
            dec_o.reg_write = 1'b1;
            case (op_i)
                OP_ADDI, OP_ADDIU: dec_o.alu_op = ALU_ADD;
                OP_SLTI:  dec_o.alu_op = ALU_SLT;
                OP_SLTIU: dec_o.alu_op = ALU_SLTU;
                OP_ANDI: begin
                    dec_o.alu_op = ALU_AND;
                    dec_o.ext    = EXT_ZERO;
                end
                OP_ORI: begin
                    dec_o.alu_op = ALU_OR;
                    dec_o.ext    = EXT_ZERO;
                end
                OP_XORI: begin
                    dec_o.alu_op = ALU_XOR;
                    dec_o.ext    = EXT_ZERO;
                end
                OP_LUI: begin
                    dec_o.alu_op = ALU_LS_LEFT;
                    dec_o.src_a  = SRC_C16;
                    dec_o.ext    = EXT_ZERO;
                end
                OP_LW: dec_o.mem_to_reg = 1'b1;
                OP_SW: begin
                    dec_o.mem_write = 1'b1;
                    dec_o.reg_write = 1'b0;
                end
                default: begin
                    dec_o.illegal   = 1'b1;
                    dec_o.reg_write = 1'b0;
                    dec_o.src_b     = SRC_REG;
                end
            endcase
        end
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID->EX pipeline register and ALU issue stage with stall/flush.
// Define ID_EX_FORWARD_EN to forward M/W results into register-sourced operands.
module id_ex_alu_issue
    import id_ex_alu_issue_pkg::*;
#(
    parameter int ALU_OP_W = ALU_OP_LENGTH,
    parameter int XLEN     = WORD_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallE,
    input  logic                flushE,
    input  logic                validD,
    input  logic [5:0]          opD,
    input  logic [5:0]          functD,
    input  logic [4:0]          shamtD,
    input  logic [15:0]         immD,
    input  logic [4:0]          rsD,
    input  logic [4:0]          rtD,
    input  logic [4:0]          rdD,
    input  logic [XLEN-1:0]     rsDataD,
    input  logic [XLEN-1:0]     rtDataD,
    input  logic                regWriteM,
    input  logic [4:0]          writeRegM,
    input  logic [XLEN-1:0]     aluOutM,
    input  logic                regWriteW,
    input  logic [4:0]          writeRegW,
    input  logic [XLEN-1:0]     resultW,
    output logic [ALU_OP_W-1:0] aluOpE,
    output logic [XLEN-1:0]     SrcA,
    output logic [XLEN-1:0]     SrcB,
    output logic [4:0]          writeRegE,
    output logic                regWriteE,
    output logic                memWriteE,
    output logic                memToRegE,
    output logic                validE,
    output logic                illegalE
);

    dec_t dec;

    alu_issue_decode u_decode (
        .op_i    (opD),
        .funct_i (functD),
        .dec_o   (dec)
    );

    logic [XLEN-1:0] imm_ext;
    logic [4:0]      dest_d;

    assign imm_ext = (dec.ext == EXT_SIGN) ? {{(XLEN-16){immD[15]}}, immD}
                                           : {{(XLEN-16){1'b0}}, immD};
    assign dest_d  = dec.dest_rd ? rdD : rtD;

    logic                valid_q,      valid_d;
    logic [ALU_OP_W-1:0] alu_op_q,     alu_op_d;
    src_sel_e            src_a_sel_q,  src_a_sel_d;
    src_sel_e            src_b_sel_q,  src_b_sel_d;
    logic [4:0]          rs_q,         rs_d;
    logic [4:0]          rt_q,         rt_d;
    logic [XLEN-1:0]     rs_data_q,    rs_data_d;
    logic [XLEN-1:0]     rt_data_q,    rt_data_d;
    logic [XLEN-1:0]     imm_q,        imm_d;
    logic [4:0]          shamt_q,      shamt_d;
    logic [4:0]          write_reg_q,  write_reg_d;
    logic                reg_write_q,  reg_write_d;
    logic                mem_write_q,  mem_write_d;
    logic                mem_to_reg_q, mem_to_reg_d;
    logic                illegal_q,    illegal_d;

    // Bubble fields match the reset values; zero indices keep a bubble out of forwarding.
    always_comb begin
        valid_d      = valid_q;
        alu_op_d     = alu_op_q;
        src_a_sel_d  = src_a_sel_q;
        src_b_sel_d  = src_b_sel_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_d        = imm_q;
        shamt_d      = shamt_q;
        write_reg_d  = write_reg_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        illegal_d    = illegal_q;

        if (flushE || (!stallE && !validD)) begin
            valid_d      = 1'b0;
            alu_op_d     = ALU_OP_W'(ALU_ADD);
            src_a_sel_d  = SRC_REG;
            src_b_sel_d  = SRC_REG;
            rs_d         = 5'd0;
            rt_d         = 5'd0;
            rs_data_d    = '0;
            rt_data_d    = '0;
            imm_d        = '0;
            shamt_d      = 5'd0;
            write_reg_d  = 5'd0;
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            illegal_d    = 1'b0;
        end else if (!stallE) begin
            valid_d      = 1'b1;
            alu_op_d     = ALU_OP_W'(dec.alu_op);
            src_a_sel_d  = dec.src_a;
            src_b_sel_d  = dec.src_b;
            rs_d         = rsD;
            rt_d         = rtD;
            rs_data_d    = rsDataD;
            rt_data_d    = rtDataD;
            imm_d        = imm_ext;
            shamt_d      = shamtD;
            write_reg_d  = dec.illegal ? 5'd0 : dest_d;
            reg_write_d  = dec.reg_write && (dest_d != 5'd0);
            mem_write_d  = dec.mem_write;
            mem_to_reg_d = dec.mem_to_reg;
            illegal_d    = dec.illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            alu_op_q     <= ALU_OP_W'(ALU_ADD);
            src_a_sel_q  <= SRC_REG;
            src_b_sel_q  <= SRC_REG;
            rs_q         <= 5'd0;
            rt_q         <= 5'd0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            shamt_q      <= 5'd0;
            write_reg_q  <= 5'd0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            alu_op_q     <= alu_op_d;
            src_a_sel_q  <= src_a_sel_d;
            src_b_sel_q  <= src_b_sel_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            shamt_q      <= shamt_d;
            write_reg_q  <= write_reg_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            illegal_q    <= illegal_d;
        end
    end

    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;

`ifdef ID_EX_FORWARD_EN
    // M is the younger producer, so it wins over W; $zero is never forwarded.
    always_comb begin
        rs_val = rs_data_q;
        if ((rs_q != 5'd0) && regWriteM && (writeRegM == rs_q)) begin
            rs_val = aluOutM;
        end else if ((rs_q != 5'd0) && regWriteW && (writeRegW == rs_q)) begin
            rs_val = resultW;
        end
    end

    always_comb begin
        rt_val = rt_data_q;
        if ((rt_q != 5'd0) && regWriteM && (writeRegM == rt_q)) begin
            rt_val = aluOutM;
        end else if ((rt_q != 5'd0) && regWriteW && (writeRegW == rt_q)) begin
            rt_val = resultW;
        end
    end
`else
    logic unused_fwd;

    assign rs_val     = rs_data_q;
    assign rt_val     = rt_data_q;
    assign unused_fwd = ^{regWriteM, writeRegM, aluOutM, regWriteW, writeRegW, resultW,
                          rs_q, rt_q};
`endif

    function automatic logic [XLEN-1:0] pick_src(input src_sel_e sel,
                                                 input logic [XLEN-1:0] reg_val,
                                                 input logic [XLEN-1:0] imm_val,
                                                 input logic [4:0] shamt_val);
        case (sel)
            SRC_SHAMT: return {{(XLEN-5){1'b0}}, shamt_val};
            SRC_IMM:   return imm_val;
            SRC_C16:   return XLEN'(16);
            default:   return reg_val;
        endcase
    endfunction

    assign SrcA      = pick_src(src_a_sel_q, rs_val, imm_q, shamt_q);
    assign SrcB      = pick_src(src_b_sel_q, rt_val, imm_q, shamt_q);
    assign aluOpE    = alu_op_q;
    assign writeRegE = write_reg_q;
    assign regWriteE = reg_write_q;
    assign memWriteE = mem_write_q;
    assign memToRegE = mem_to_reg_q;
    assign validE    = valid_q;
    assign illegalE  = illegal_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Self-checking bench for id_ex_alu_issue: directed cases plus random traffic,
// expected E-stage values queued at drive time and compared one cycle later.
`timescale 1ns/1ps
module tb_id_ex_alu_issue;
    import id_ex_alu_issue_pkg::*;

    localparam int W = 78;
`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stallE, flushE, validD;
    logic [5:0]  opD, functD;
    logic [4:0]  shamtD, rsD, rtD, rdD;
    logic [15:0] immD;
    logic [31:0] rsDataD, rtDataD;
    logic        regWriteM, regWriteW;
    logic [4:0]  writeRegM, writeRegW;
    logic [31:0] aluOutM, resultW;
    logic [3:0]  aluOpE;
    logic [31:0] SrcA, SrcB;
    logic [4:0]  writeRegE;
    logic        regWriteE, memWriteE, memToRegE, validE, illegalE;

    always #5 clk = ~clk;

    id_ex_alu_issue dut (
        .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .validD(validD),
        .opD(opD), .functD(functD), .shamtD(shamtD), .immD(immD),
        .rsD(rsD), .rtD(rtD), .rdD(rdD), .rsDataD(rsDataD), .rtDataD(rtDataD),
        .regWriteM(regWriteM), .writeRegM(writeRegM), .aluOutM(aluOutM),
        .regWriteW(regWriteW), .writeRegW(writeRegW), .resultW(resultW),
        .aluOpE(aluOpE), .SrcA(SrcA), .SrcB(SrcB), .writeRegE(writeRegE),
        .regWriteE(regWriteE), .memWriteE(memWriteE), .memToRegE(memToRegE),
        .validE(validE), .illegalE(illegalE)
    );

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Snapshot of the instruction the E stage should currently hold.
    logic        m_valid = 1'b0;
    logic [5:0]  m_op, m_funct;
    logic [4:0]  m_shamt, m_rs, m_rt, m_rd;
    logic [15:0] m_imm;
    logic [31:0] m_rsdata, m_rtdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] regv);
        if (FWD && idx != 5'd0 && regWriteM && writeRegM == idx) return aluOutM;
        if (FWD && idx != 5'd0 && regWriteW && writeRegW == idx) return resultW;
        return regv;
    endfunction

    function automatic logic [W-1:0] model();
        logic rw, mw, mtr, ill;
        logic [4:0] dst;
        logic [3:0] aop;
        logic [31:0] a, b, se, ze;
        if (!m_valid) return {5'b0, 5'd0, ALU_ADD, 64'h0};
        se = {{16{m_imm[15]}}, m_imm};
        ze = {16'h0, m_imm};
        a = fwd(m_rs, m_rsdata);
        b = fwd(m_rt, m_rtdata);
        rw = 1'b1; mw = 1'b0; mtr = 1'b0; ill = 1'b0; aop = ALU_ADD;
        if (m_op == 6'h00) begin
            dst = m_rd;
            case (m_funct)
                6'h20, 6'h21: aop = ALU_ADD;
                6'h22, 6'h23: aop = ALU_SUB;
                6'h24: aop = ALU_AND;
                6'h25: aop = ALU_OR;
                6'h26: aop = ALU_XOR;
                6'h27: aop = ALU_NOR;
                6'h2A: aop = ALU_SLT;
                6'h2B: aop = ALU_SLTU;
                6'h00: begin aop = ALU_LS_LEFT;  a = {27'h0, m_shamt}; end
                6'h02: begin aop = ALU_LS_RIGHT; a = {27'h0, m_shamt}; end
                6'h03: begin aop = ALU_AS_RIGHT; a = {27'h0, m_shamt}; end
                6'h04: aop = ALU_LS_LEFT;
                6'h06: aop = ALU_LS_RIGHT;
                6'h07: aop = ALU_AS_RIGHT;
                default: ill = 1'b1;
            endcase
        end else begin
            dst = m_rt;
            case (m_op)
                6'h08, 6'h09: begin aop = ALU_ADD;  b = se; end
                6'h0A: begin aop = ALU_SLT;  b = se; end
                6'h0B: begin aop = ALU_SLTU; b = se; end
                6'h0C: begin aop = ALU_AND;  b = ze; end
                6'h0D: begin aop = ALU_OR;   b = ze; end
                6'h0E: begin aop = ALU_XOR;  b = ze; end
                6'h0F: begin aop = ALU_LS_LEFT; a = 32'd16; b = ze; end
                6'h23: begin aop = ALU_ADD; b = se; mtr = 1'b1; end
                6'h2B: begin aop = ALU_ADD; b = se; mw = 1'b1; rw = 1'b0; end
                default: ill = 1'b1;
            endcase
        end
        if (ill) begin
            rw = 1'b0; mw = 1'b0; mtr = 1'b0; aop = ALU_ADD;
        end
        if (dst == 5'd0) rw = 1'b0;
        return {1'b1, rw, mw, mtr, ill, dst, aop, a, b};
    endfunction

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] funct,
                         input logic [4:0] shamt, input logic [15:0] imm,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd);
        validD = v; opD = op; functD = funct; shamtD = shamt; immD = imm;
        rsD = rs; rtD = rt; rdD = rd; rsDataD = rsd; rtDataD = rtd;
    endtask

    task automatic set_fwd(input logic rwm, input logic [4:0] wm, input logic [31:0] om,
                           input logic rww, input logic [4:0] ww, input logic [31:0] rsw);
        regWriteM = rwm; writeRegM = wm; aluOutM = om;
        regWriteW = rww; writeRegW = ww; resultW = rsw;
    endtask

    // Called at a negedge with inputs set: queue expectation, clock, compare.
    task automatic tick();
        logic [W-1:0] e;
        if (rst || flushE) begin
            m_valid = 1'b0;
        end else if (!stallE) begin
            m_valid = validD; m_op = opD; m_funct = functD; m_shamt = shamtD; m_imm = immD;
            m_rs = rsD; m_rt = rtD; m_rd = rdD; m_rsdata = rsDataD; m_rtdata = rtDataD;
        end
        exp_q.push_back(model());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("validE",    {31'b0, validE},    {31'b0, e[77]});
        check("regWriteE", {31'b0, regWriteE}, {31'b0, e[76]});
        check("memWriteE", {31'b0, memWriteE}, {31'b0, e[75]});
        check("memToRegE", {31'b0, memToRegE}, {31'b0, e[74]});
        check("illegalE",  {31'b0, illegalE},  {31'b0, e[73]});
        check("aluOpE",    {28'b0, aluOpE},    {28'b0, e[67:64]});
        if (!e[73]) begin
            check("writeRegE", {27'b0, writeRegE}, {27'b0, e[72:68]});
            check("SrcA", SrcA, e[63:32]);
            check("SrcB", SrcB, e[31:0]);
        end
        @(negedge clk);
    endtask

    logic [5:0] op_tab [12] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h0B, 6'h0C,
                                6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F};
    logic [5:0] fn_tab [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h3F};

    initial begin
        rst = 1'b1; stallE = 1'b0; flushE = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        drive(1'b1, 6'h00, 6'h20, 5'd0, 16'h0, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Constant arithmetic shift: amount in SrcA, value in SrcB
        drive(1'b1, 6'h00, 6'h03, 5'd4, 16'h0, 5'd1, 5'd2, 5'd3, 32'h0, 32'h80000000);
        tick();
        drive(1'b1, 6'h08, 6'h00, 5'd0, 16'hFFFF, 5'd1, 5'd4, 5'd0, 32'h10, 32'h0);
        tick();
        drive(1'b1, 6'h0D, 6'h00, 5'd0, 16'hFFFF, 5'd1, 5'd4, 5'd0, 32'h10, 32'h0);
        tick();
        drive(1'b1, 6'h0F, 6'h00, 5'd0, 16'h1234, 5'd0, 5'd6, 5'd0, 32'h0, 32'h0);
        tick();
        drive(1'b1, 6'h00, 6'h22, 5'd0, 16'h0, 5'd8, 5'd9, 5'd10, 32'hCAFE0000, 32'h0000BEEF);
        tick();
        drive(1'b1, 6'h00, 6'h06, 5'd7, 16'h0, 5'd8, 5'd9, 5'd10, 32'h3, 32'hF0F0F0F0);
        tick();
        drive(1'b1, 6'h23, 6'h00, 5'd0, 16'h8000, 5'd2, 5'd12, 5'd0, 32'h1000, 32'h0);
        tick();
        drive(1'b1, 6'h2B, 6'h00, 5'd0, 16'h0004, 5'd2, 5'd9, 5'd0, 32'h1000, 32'h55);
        tick();
        // Destination $zero suppresses the write
        drive(1'b1, 6'h00, 6'h20, 5'd0, 16'h0, 5'd1, 5'd2, 5'd0, 32'h1, 32'h2);
        tick();

        // Stall holds for three cycles despite new D inputs, then flush beats stall
        drive(1'b1, 6'h00, 6'h25, 5'd0, 16'h0, 5'd3, 5'd4, 5'd7, 32'hA5A5, 32'h5A5A);
        tick();
        stallE = 1'b1;
        drive(1'b1, 6'h0E, 6'h00, 5'd0, 16'h7777, 5'd9, 5'd11, 5'd0, 32'h1, 32'h2);
        tick(); tick(); tick();
        flushE = 1'b1;
        tick();
        flushE = 1'b0; stallE = 1'b0;

        // Forwarding priority: M over W, and nothing for index 0
        set_fwd(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
        drive(1'b1, 6'h00, 6'h20, 5'd0, 16'h0, 5'd5, 5'd6, 5'd7, 32'h1111, 32'h2222);
        tick();
        stallE = 1'b1;
        set_fwd(1'b0, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
        tick();
        stallE = 1'b0;
        set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        drive(1'b1, 6'h00, 6'h20, 5'd0, 16'h0, 5'd0, 5'd0, 5'd7, 32'h3333, 32'h4444);
        tick();
        set_fwd(1'b1, 5'd6, 32'hCC, 1'b0, 5'd0, 32'h0);
        drive(1'b1, 6'h0C, 6'h00, 5'd0, 16'h00F0, 5'd6, 5'd6, 5'd0, 32'h5555, 32'h6666);
        tick();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Illegal opcode and funct, then an invalid slot
        drive(1'b1, 6'h3F, 6'h00, 5'd0, 16'h0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
        tick();
        drive(1'b1, 6'h00, 6'h3F, 5'd0, 16'h0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
        tick();
        drive(1'b0, 6'h00, 6'h20, 5'd0, 16'h0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
        tick();

        for (int i = 0; i < 400; i++) begin
            stallE = ($urandom_range(0, 5) == 0);
            flushE = ($urandom_range(0, 11) == 0);
            set_fwd($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom(),
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom());
            drive($urandom_range(0, 7) != 0, op_tab[$urandom_range(0, 11)],
                  fn_tab[$urandom_range(0, 16)], 5'($urandom_range(0, 31)),
                  16'($urandom()), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom(), $urandom());
            tick();
        end
        stallE = 1'b0; flushE = 1'b0;
        rst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
